branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 139 +++++++++++++
 tb/tb_branch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller: drives comparator select, PC redirect,
// front-end flush and wrong-path kill, plus saturating branch statistics.
module branch_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ex_valid,
   input  logic             i_ex_is_branch,
   input  logic             i_ex_is_jump,
   input  logic [2:0]       i_ex_funct3,
   input  logic             i_br_taken,
   input  logic [31:0]      i_ex_target,
   input  logic             i_stall,
   input  logic             i_cnt_clr,
   output logic [2:0]       o_br_type,
   output logic             o_pc_sel,
   output logic [31:0]      o_pc_target,
   output logic             o_flush_if,
   output logic             o_ex_kill,
   output logic             o_br_illegal,
   output logic [CNT_W-1:0] o_branch_cnt,
   output logic [CNT_W-1:0] o_taken_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REDIR = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [1:0]       r_cnt;
   logic [1:0]       w_cnt_nxt;
   logic [31:0]      r_pc_target;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_taken_cnt;
   logic             w_legal;
   logic             w_resolve;
   logic             w_redirect;
   logic             w_br_count;

   // funct3 010/011 are reserved branch encodings
   assign w_legal    = (i_ex_funct3 != 3'b010) && (i_ex_funct3 != 3'b011);
   assign w_resolve  = (r_state == S_IDLE) && i_ex_valid && !i_stall;
   assign w_redirect = w_resolve &&
                       (i_ex_is_jump || (i_ex_is_branch && w_legal && i_br_taken));
   assign w_br_count = w_resolve && i_ex_is_branch && !i_ex_is_jump && w_legal;

   always_comb begin
      o_br_type = 3'b010;
      if (i_ex_is_branch && w_legal) begin
         o_br_type = i_ex_funct3;
      end else begin
         o_br_type = 3'b010;
      end
   end

   assign o_br_illegal = w_resolve && i_ex_is_branch && !i_ex_is_jump && !w_legal;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_redirect) begin
               w_state_nxt = S_REDIR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REDIR: begin
            if (i_stall) begin
               w_state_nxt = S_REDIR;
            end else if (FLUSH_CYCLES == 1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 2'd0;
            end else begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = FLUSH_INIT;
            end
         end
         S_FLUSH: begin
            if (i_stall) begin
               w_state_nxt = S_FLUSH;
            end else if (r_cnt == 2'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 2'd0;
            end else begin
               w_cnt_nxt   = r_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 2'd0;
         r_pc_target <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_redirect) begin
            r_pc_target <= i_ex_target;
         end
      end
   end

   // Clear wins over increment; both counters stick at all-ones
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
         r_branch_cnt <= {CNT_W{1'b0}};
         r_taken_cnt  <= {CNT_W{1'b0}};
      end else begin
         if (w_br_count && (r_branch_cnt != CNT_MAX)) begin
            r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (w_redirect && (r_taken_cnt != CNT_MAX)) begin
            r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign o_pc_sel     = (r_state == S_REDIR);
   assign o_flush_if   = (r_state == S_REDIR) || (r_state == S_FLUSH);
   assign o_ex_kill    = (r_state == S_REDIR) || (r_state == S_FLUSH);
   assign o_pc_target  = r_pc_target;
   assign o_branch_cnt = r_branch_cnt;
   assign o_taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: two instances (FLUSH_CYCLES=1 and 3, 4-bit
// counters) share one stimulus stream; a queue feeds a negedge monitor.
module tb_branch_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [2:0]  ex_funct3;
   logic        br_taken;
   logic [31:0] ex_target;
   logic        stall;
   logic        cnt_clr;

   logic [2:0]    br_type_a, br_type_b;
   logic          pc_sel_a, pc_sel_b;
   logic [31:0]   pc_target_a, pc_target_b;
   logic          flush_a, flush_b;
   logic          kill_a, kill_b;
   logic          ill_a, ill_b;
   logic [CW-1:0] bcnt_a, bcnt_b;
   logic [CW-1:0] tcnt_a, tcnt_b;

   typedef struct packed {
      logic [2:0]  br_type;
      logic [1:0]  ill;
      logic [1:0]  psel;
      logic [1:0]  fl;
      logic [1:0]  kill;
      logic [63:0] tgt;
      logic [7:0]  bcnt;
      logic [7:0]  tcnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // reference model: outstanding flush cycles, redirect phase, counters
   int          fc[2];
   int          fl_left[2];
   bit          redir[2];
   logic [31:0] mtgt[2];
   int          mb[2];
   int          mt[2];

   branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(CW)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch),
      .i_ex_is_jump(ex_is_jump), .i_ex_funct3(ex_funct3), .i_br_taken(br_taken),
      .i_ex_target(ex_target), .i_stall(stall), .i_cnt_clr(cnt_clr),
      .o_br_type(br_type_a), .o_pc_sel(pc_sel_a), .o_pc_target(pc_target_a),
      .o_flush_if(flush_a), .o_ex_kill(kill_a), .o_br_illegal(ill_a),
      .o_branch_cnt(bcnt_a), .o_taken_cnt(tcnt_a));

   branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CW)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch),
      .i_ex_is_jump(ex_is_jump), .i_ex_funct3(ex_funct3), .i_br_taken(br_taken),
      .i_ex_target(ex_target), .i_stall(stall), .i_cnt_clr(cnt_clr),
      .o_br_type(br_type_b), .o_pc_sel(pc_sel_b), .o_pc_target(pc_target_b),
      .o_flush_if(flush_b), .o_ex_kill(kill_b), .o_br_illegal(ill_b),
      .o_branch_cnt(bcnt_b), .o_taken_cnt(tcnt_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         fl_left[k] = 0;
         redir[k]   = 1'b0;
         mtgt[k]    = 32'd0;
         mb[k]      = 0;
         mt[k]      = 0;
      end
   endtask

   // Drive one cycle, push the expected outputs, then advance the model
   task automatic step(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                       input bit tk, input logic [31:0] tgt, input bit st,
                       input bit clr, input bit rs);
      exp_t e;
      bit   legal, res, red;
      @(posedge clk);
      #1;
      ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
      br_taken = tk; ex_target = tgt; stall = st; cnt_clr = clr; rst = rs;
      legal = (f3 != 3'd2) && (f3 != 3'd3);
      e = '0;
      e.br_type = (br && legal) ? f3 : 3'b010;
      for (int k = 0; k < 2; k++) begin
         res = (fl_left[k] == 0) && v && !st;
         red = res && (jmp || (br && legal && tk));
         e.ill[k]             = res && br && !jmp && !legal;
         e.psel[k]            = redir[k];
         e.fl[k]              = (fl_left[k] > 0);
         e.kill[k]            = (fl_left[k] > 0);
         e.tgt[k*32 +: 32]    = mtgt[k];
         e.bcnt[k*4 +: 4]     = 4'(mb[k]);
         e.tcnt[k*4 +: 4]     = 4'(mt[k]);
         if (rs) begin
            fl_left[k] = 0; redir[k] = 1'b0; mtgt[k] = 32'd0; mb[k] = 0; mt[k] = 0;
         end else begin
            if (red) mtgt[k] = tgt;
            if (clr) begin
               mb[k] = 0; mt[k] = 0;
            end else begin
               if (res && br && !jmp && legal && mb[k] < CMAX) mb[k]++;
               if (red && mt[k] < CMAX) mt[k]++;
            end
            if (red) begin
               fl_left[k] = fc[k]; redir[k] = 1'b1;
            end else if (fl_left[k] > 0 && !st) begin
               fl_left[k]--; redir[k] = 1'b0;
            end
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 0, 32'd0, 0, 0, 0);
   endtask

   // monitor: compare every presented cycle against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("br_type",    {58'd0, br_type_a, br_type_b}, {58'd0, e.br_type, e.br_type});
         chk("br_illegal", {62'd0, ill_b, ill_a},        {62'd0, e.ill});
         chk("pc_sel",     {62'd0, pc_sel_b, pc_sel_a},  {62'd0, e.psel});
         chk("flush_if",   {62'd0, flush_b, flush_a},    {62'd0, e.fl});
         chk("ex_kill",    {62'd0, kill_b, kill_a},      {62'd0, e.kill});
         chk("pc_target",  {pc_target_b, pc_target_a},   e.tgt);
         chk("branch_cnt", {56'd0, bcnt_b, bcnt_a},      {56'd0, e.bcnt});
         chk("taken_cnt",  {56'd0, tcnt_b, tcnt_a},      {56'd0, e.tcnt});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      fc[0] = 1; fc[1] = 3;
      rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
      ex_funct3 = 3'd0; br_taken = 1'b0; ex_target = 32'd0; stall = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      step(0, 0, 0, 3'd0, 0, 32'd0, 0, 0, 1);
      idle(1);
      // BEQ taken
      step(1, 1, 0, 3'd0, 1, 32'h0000_0100, 0, 0, 0);
      idle(4);
      // BNE not taken
      step(1, 1, 0, 3'd1, 0, 32'h0000_0200, 0, 0, 0);
      idle(2);
      // JAL, then a 3-cycle stall with a taken branch waiting in EX
      step(1, 0, 1, 3'd0, 0, 32'h0000_0300, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 1, 32'h0000_0DEA, 1, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0DEA, 0, 0, 0);
      idle(5);
      // redirect, stall on the second flush cycle
      step(1, 1, 0, 3'd4, 1, 32'h0000_0400, 0, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0BAD, 0, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0BAD, 0, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0BAD, 1, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0BAD, 0, 0, 0);
      idle(3);
      // saturate branch_cnt, then clear together with a resolution
      for (int i = 0; i < 20; i++) step(1, 1, 0, 3'd5, 0, 32'd0, 0, 0, 0);
      step(1, 1, 0, 3'd0, 1, 32'h0000_0500, 0, 1, 0);
      idle(4);
      // reserved funct3, then reset in the middle of a redirect
      step(1, 1, 0, 3'd3, 1, 32'h0000_0600, 0, 0, 0);
      step(1, 1, 0, 3'd2, 1, 32'h0000_0604, 0, 0, 0);
      idle(1);
      step(1, 0, 1, 3'd0, 0, 32'h0000_0700, 0, 0, 0);
      step(0, 0, 0, 3'd0, 0, 32'd0, 1, 0, 1);
      idle(3);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
              $urandom_range(0, 80) == 0);
      end
      idle(2);
      @(posedge clk);
      @(posedge clk);
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
